// File: rtl/ip_stride_pkg.sv
// Shared types and geometry for the IP-indexed stride prefetcher.
// Addresses are byte addresses; prefetch bookkeeping is done on cache-line addresses (cla).
package ip_stride_pkg;

   localparam int LOG2_BLOCK_SIZE = 6;
   localparam int LOG2_PAGE_SIZE  = 12;
   localparam int ADDR_W          = 64;
   localparam int CLA_W           = ADDR_W - LOG2_BLOCK_SIZE;
   localparam int CONF_W_MAX      = 8;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [CLA_W-1:0]  cla_t;
   typedef logic [CLA_W-1:0]  stride_t;

   // conf is sized for the widest supported counter; only CONF_BITS of it are ever non-zero
   typedef struct packed {
      logic                  valid;
      addr_t                 ip;
      cla_t                  last_cla;
      stride_t               stride;
      logic [CONF_W_MAX-1:0] conf;
   } tracker_t;

   typedef enum logic {
      ST_IDLE,
      ST_ISSUE
   } state_t;

   function automatic addr_t cla_to_addr(input cla_t c);
      return {c, {LOG2_BLOCK_SIZE{1'b0}}};
   endfunction

   function automatic logic same_page(input cla_t a, input cla_t b);
      return a[CLA_W-1:LOG2_PAGE_SIZE-LOG2_BLOCK_SIZE] == b[CLA_W-1:LOG2_PAGE_SIZE-LOG2_BLOCK_SIZE];
   endfunction

endpackage

// File: rtl/pf_fifo.sv
// Prefetch queue: register-file FIFO whose head is presented from output flops,
// so a push into an empty queue becomes visible on the following cycle.
module pf_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic             dout_valid,
   output logic [WIDTH-1:0] dout
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr, rd_next;
   logic [AW:0]      cnt, cnt_next;
   logic             do_push, do_pop;
   logic [WIDTH-1:0] head_next;

   assign full     = (cnt == (AW+1)'(DEPTH));
   assign empty    = (cnt == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign rd_next  = rd_ptr + AW'(do_pop);
   assign cnt_next = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);

   // rd_next can only alias wr_ptr during a push when the queue is draining to empty
   assign head_next = (do_push && (wr_ptr == rd_next)) ? din : mem[rd_next];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         cnt        <= '0;
         dout_valid <= 1'b0;
         dout       <= '0;
      end else begin
         rd_ptr     <= rd_next;
         wr_ptr     <= wr_ptr + AW'(do_push);
         cnt        <= cnt_next;
         dout_valid <= (cnt_next != '0);
         dout       <= (cnt_next != '0) ? head_next : '0;
      end
   end

endmodule

// File: rtl/ip_stride_conf.sv
// IP-indexed stride prefetcher with per-tracker confidence; a confident hit
// launches a burst of up to DEGREE in-page prefetches into pf_fifo.
module ip_stride_conf
   import ip_stride_pkg::*;
#(
   parameter int TRACKERS    = 64,
   parameter int DEGREE      = 4,
   parameter int CONF_BITS   = 2,
   parameter int CONF_THRESH = 2,
   parameter int QDEPTH      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [63:0] req_addr_i,
   input  logic [63:0] req_ip_i,
   output logic        pf_valid_o,
   input  logic        pf_ready_i,
   output logic [63:0] pf_addr_o,
   output logic [15:0] drop_cnt_o
);

   localparam int TW = $clog2(TRACKERS);
   localparam int KW = $clog2(DEGREE + 1);
   localparam logic [CONF_W_MAX-1:0] CONF_MAX = CONF_W_MAX'((1 << CONF_BITS) - 1);

   tracker_t trk [TRACKERS];
   logic [TW-1:0] victim;

   state_t  state, state_n;
   logic [KW-1:0] k, k_n;
   cla_t    lat_cla, cand_cla;
   stride_t lat_stride;
   logic [15:0] drop_cnt;

   logic    accept, hit, free_found, trigger;
   logic [TW-1:0] hit_idx, free_idx, alloc_idx;
   cla_t    req_cla;
   stride_t new_stride;
   logic    stride_zero, stride_same;
   logic [CONF_W_MAX-1:0] conf_upd;

   logic    pf_push, drop, fifo_full, fifo_valid, pop;
   addr_t   fifo_dout;
   logic    unused_fifo_empty;
   logic    unused_addr_lsbs;

   assign unused_addr_lsbs = ^req_addr_i[LOG2_BLOCK_SIZE-1:0];

   assign req_ready_o = ~rst & (state == ST_IDLE);
   assign accept      = req_valid_i & req_ready_o;
   assign req_cla     = req_addr_i[ADDR_W-1:LOG2_BLOCK_SIZE];

   // Descending scan so the lowest matching / lowest free index wins
   always_comb begin
      hit        = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = TRACKERS - 1; i >= 0; i--) begin
         if (trk[i].valid && (trk[i].ip == req_ip_i)) begin
            hit     = 1'b1;
            hit_idx = TW'(i);
         end
         if (!trk[i].valid) begin
            free_found = 1'b1;
            free_idx   = TW'(i);
         end
      end
   end

   assign alloc_idx   = free_found ? free_idx : victim;
   assign new_stride  = req_cla - trk[hit_idx].last_cla;
   assign stride_zero = (new_stride == '0);
   assign stride_same = (new_stride == trk[hit_idx].stride);

   always_comb begin
      conf_upd = '0;
      if (stride_same)
         conf_upd = (trk[hit_idx].conf == CONF_MAX) ? trk[hit_idx].conf
                                                    : trk[hit_idx].conf + 1'b1;
   end

   assign trigger = accept & hit & ~stride_zero & (conf_upd >= CONF_W_MAX'(CONF_THRESH));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TRACKERS; i++) trk[i].valid <= 1'b0;
         victim <= '0;
      end else if (accept) begin
         if (hit) begin
            if (!stride_zero) begin
               trk[hit_idx].last_cla <= req_cla;
               trk[hit_idx].stride   <= new_stride;
               trk[hit_idx].conf     <= conf_upd;
            end
         end else begin
            trk[alloc_idx] <= '{valid: 1'b1, ip: req_ip_i, last_cla: req_cla,
                                stride: '0, conf: '0};
            if (!free_found) victim <= victim + TW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (trigger) begin
         lat_cla    <= req_cla;
         lat_stride <= new_stride;
      end
   end

   // Modular 58-bit arithmetic; negative strides wrap naturally
   assign cand_cla = lat_cla + lat_stride * cla_t'(k);

   always_comb begin
      state_n = state;
      k_n     = k;
      pf_push = 1'b0;
      drop    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (trigger) begin
               state_n = ST_ISSUE;
               k_n     = KW'(1);
            end
         end
         ST_ISSUE: begin
            if (!same_page(cand_cla, lat_cla)) begin
               state_n = ST_IDLE;
            end else begin
               if (fifo_full) drop = 1'b1;
               else           pf_push = 1'b1;
               if (k == KW'(DEGREE)) state_n = ST_IDLE;
               else                  k_n = k + KW'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         k        <= '0;
         drop_cnt <= '0;
      end else begin
         state <= state_n;
         k     <= k_n;
         if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      end
   end

   assign pop = pf_valid_o & pf_ready_i;

   pf_fifo #(
      .WIDTH (ADDR_W),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (pf_push),
      .din        (cla_to_addr(cand_cla)),
      .pop        (pop),
      .full       (fifo_full),
      .empty      (unused_fifo_empty),
      .dout_valid (fifo_valid),
      .dout       (fifo_dout)
   );

   assign pf_valid_o = ~rst & fifo_valid;
   assign pf_addr_o  = rst ? '0 : fifo_dout;
   assign drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_ip_stride_conf.sv
// Directed bench for ip_stride_conf: training, negative strides, page crossing,
// FIFO overflow, tracker eviction and reset in the middle of a burst.
module tb_ip_stride_conf;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [63:0] req_addr_i;
   logic [63:0] req_ip_i;
   logic        pf_valid_o;
   logic        pf_ready_i;
   logic [63:0] pf_addr_o;
   logic [15:0] drop_cnt_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] cap [$];
   int base;

   ip_stride_conf #(
      .TRACKERS    (4),
      .DEGREE      (4),
      .CONF_BITS   (2),
      .CONF_THRESH (2),
      .QDEPTH      (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .req_ip_i    (req_ip_i),
      .pf_valid_o  (pf_valid_o),
      .pf_ready_i  (pf_ready_i),
      .pf_addr_o   (pf_addr_o),
      .drop_cnt_o  (drop_cnt_o)
   );

   always #5 clk = ~clk;

   // Record each beat that will be popped on the next rising edge
   always @(negedge clk) if (!rst && pf_valid_o && pf_ready_i) cap.push_back(pf_addr_o);

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; returns just after the accepting edge
   task automatic send(input logic [63:0] ip, input logic [63:0] addr);
      int n = 0;
      req_valid_i = 1'b1;
      req_ip_i    = ip;
      req_addr_i  = addr;
      @(negedge clk);
      while (!req_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("req_ready_timeout", 64'(req_ready_o), 64'd1);
      @(posedge clk);
      #1 req_valid_i = 1'b0;
   endtask

   task automatic chk_caps(input string tag, input int from, input logic [63:0] e0,
                           input logic [63:0] e1, input logic [63:0] e2, input logic [63:0] e3);
      logic [63:0] exp [4];
      exp = '{e0, e1, e2, e3};
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s[%0d]", tag, i), (from + i < cap.size()) ? cap[from + i] : 64'hDEAD, exp[i]);
   endtask

   initial begin
      rst = 1'b1;
      req_valid_i = 1'b0;
      req_addr_i  = '0;
      req_ip_i    = '0;
      pf_ready_i  = 1'b1;
      cyc(3);
      @(negedge clk);
      chk("rst_ready", 64'(req_ready_o), 64'd0);
      chk("rst_pf_valid", 64'(pf_valid_o), 64'd0);
      chk("rst_pf_addr", pf_addr_o, 64'd0);
      chk("rst_drop", 64'(drop_cnt_o), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 64'(req_ready_o), 64'd1);
      cyc(1);

      // Positive stride +1 line, with first-prefetch latency
      base = cap.size();
      send(64'h400, 64'h10000);
      send(64'h400, 64'h10040);
      send(64'h400, 64'h10080);
      send(64'h400, 64'h100C0);
      @(negedge clk);
      chk("lat_n1_valid", 64'(pf_valid_o), 64'd0);
      @(negedge clk);
      chk("lat_n2_valid", 64'(pf_valid_o), 64'd1);
      chk("lat_n2_addr", pf_addr_o, 64'h10100);
      cyc(10);
      chk("pos_count", 64'(cap.size() - base), 64'd4);
      chk_caps("pos", base, 64'h10100, 64'h10140, 64'h10180, 64'h101C0);

      // Negative stride -4 lines
      base = cap.size();
      send(64'h500, 64'h20F00);
      send(64'h500, 64'h20E00);
      send(64'h500, 64'h20D00);
      send(64'h500, 64'h20C00);
      cyc(10);
      chk("neg_count", 64'(cap.size() - base), 64'd4);
      chk_caps("neg", base, 64'h20B00, 64'h20A00, 64'h20900, 64'h20800);

      // Stride +0x400 bytes: second candidate leaves the page
      base = cap.size();
      send(64'h600, 64'h2FC00);
      send(64'h600, 64'h30000);
      send(64'h600, 64'h30400);
      send(64'h600, 64'h30800);
      cyc(10);
      chk("page_count", 64'(cap.size() - base), 64'd1);
      chk("page_addr", (base < cap.size()) ? cap[base] : 64'hDEAD, 64'h30C00);
      chk("page_ready", 64'(req_ready_o), 64'd1);

      // Backpressure: three bursts into an 8-deep queue
      base = cap.size();
      pf_ready_i = 1'b0;
      for (int i = 0; i < 6; i++) send(64'h700, 64'h40000 + 64'(i) * 64'h40);
      cyc(8);
      chk("ovf_drop", 64'(drop_cnt_o), 64'd4);
      chk("ovf_no_pop", 64'(cap.size() - base), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ovf_hold_valid", 64'(pf_valid_o), 64'd1);
         chk("ovf_hold_addr", pf_addr_o, 64'h40100);
      end
      cyc(1);
      pf_ready_i = 1'b1;
      cyc(12);
      chk("ovf_count", 64'(cap.size() - base), 64'd8);
      chk_caps("ovf_a", base, 64'h40100, 64'h40140, 64'h40180, 64'h401C0);
      chk_caps("ovf_b", base + 4, 64'h40140, 64'h40180, 64'h401C0, 64'h40200);
      chk("ovf_drop_kept", 64'(drop_cnt_o), 64'd4);

      // Reset on the second ISSUE cycle abandons the burst
      base = cap.size();
      send(64'h700, 64'h40180);
      cyc(1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_pf_valid", 64'(pf_valid_o), 64'd0);
      chk("midrst_ready", 64'(req_ready_o), 64'd0);
      cyc(2);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_rel_ready", 64'(req_ready_o), 64'd1);
      chk("midrst_rel_valid", 64'(pf_valid_o), 64'd0);
      chk("midrst_rel_drop", 64'(drop_cnt_o), 64'd0);
      cyc(10);
      chk("midrst_no_pf", 64'(cap.size() - base), 64'd0);
      chk("midrst_valid_low", 64'(pf_valid_o), 64'd0);

      // Eviction: fifth IP replaces tracker 0, so the trained IP must retrain
      base = cap.size();
      send(64'h900, 64'h60000);
      send(64'h900, 64'h60040);
      send(64'h900, 64'h60080);
      send(64'h900, 64'h600C0);
      cyc(10);
      chk("evict_train", 64'(cap.size() - base), 64'd4);
      send(64'hA00, 64'h70000);
      send(64'hB00, 64'h70000);
      send(64'hC00, 64'h70000);
      send(64'hD00, 64'h70000);
      base = cap.size();
      send(64'h900, 64'h60100);
      @(negedge clk);
      chk("evict_realloc_ready", 64'(req_ready_o), 64'd1);
      send(64'h900, 64'h60140);
      send(64'h900, 64'h60180);
      cyc(10);
      chk("evict_no_pf", 64'(cap.size() - base), 64'd0);
      send(64'h900, 64'h601C0);
      cyc(10);
      chk("evict_retrain_count", 64'(cap.size() - base), 64'd4);
      chk("evict_retrain_first", (base < cap.size()) ? cap[base] : 64'hDEAD, 64'h60200);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/ip_stride_conf.md
IP_STRIDE_CONF -- requirements
Module: ip_stride_conf

Interface
REQ-001 SHALL have parameter TRACKERS, default 64; number of fully-associative IP trackers, power of 2, 4..256.
REQ-002 SHALL have parameter DEGREE, default 4; maximum prefetches per trigger, 1..8.
REQ-003 SHALL have parameter CONF_BITS, default 2; width of each tracker's saturating confidence counter.
REQ-004 SHALL have parameter CONF_THRESH, default 2; confidence at or above which prefetches are issued.
REQ-005 SHALL have parameter QDEPTH, default 8; prefetch output FIFO depth, power of 2.
REQ-006 SHALL have port clk, input, 1; clock, all state on rising edge.
REQ-007 SHALL have port rst, input, 1; reset, synchronous, active-high.
REQ-008 SHALL have ports req_valid_i in 1, req_ready_o out 1, req_addr_i in 64, req_ip_i in 64; demand-access request, valid/ready handshake.
REQ-009 SHALL have ports pf_valid_o out 1, pf_ready_i in 1, pf_addr_o out 64; prefetch output, valid/ready, block-aligned address.
REQ-010 SHALL have port drop_cnt_o, output, 16; saturating count of prefetches dropped because the FIFO was full.

Function
REQ-011 SHALL accept a request only on a cycle where req_valid_i and req_ready_o are both high; cla = addr >> 6.
REQ-012 SHALL hold req_ready_o high in IDLE and low in ISSUE.
REQ-013 SHALL, on an accepted request, match req_ip_i against all valid trackers; at most one tracker matches.
REQ-014 SHALL, on a miss, allocate the lowest-index invalid tracker, else the tracker at a round-robin victim pointer; the pointer advances modulo TRACKERS only on victim replacement.
REQ-015 SHALL initialise an allocated tracker with ip, last_cla = cla, stride 0, conf 0, valid 1, and issue no prefetch.
REQ-016 SHALL, on a hit, compute stride = cla - last_cla as a 58-bit two's-complement value.
REQ-017 SHALL, on a hit with stride 0, leave the tracker unchanged and issue no prefetch.
REQ-018 SHALL, on a hit with stride equal to the stored stride, saturating-increment conf; otherwise it SHALL store the new stride and clear conf; last_cla = cla in both cases.
REQ-019 SHALL transition IDLE -> ISSUE on the cycle after a hit whose post-update conf >= CONF_THRESH, latching cla, stride and k = 1.
REQ-020 SHALL, in ISSUE, produce one candidate per cycle: cand = (cla + k*stride) << 6, using modular 58-bit arithmetic.
REQ-021 SHALL return to IDLE without pushing when cand is not in the same 4 KiB page as the latched address (addr >> 12 mismatch); a page crossing terminates the burst.
REQ-022 SHALL push an in-page cand into the FIFO if the FIFO is not full; otherwise it SHALL drop cand, increment drop_cnt_o (saturating at 0xFFFF) and continue the burst.
REQ-023 SHALL return to IDLE after k = DEGREE has been processed; ISSUE SHALL therefore last at most DEGREE cycles.
REQ-024 SHALL present a pushed entry on pf_valid_o/pf_addr_o no earlier than the cycle after the push, in FIFO order; pf_addr_o SHALL be stable while pf_valid_o is high and pf_ready_i is low.
REQ-025 SHALL, when a pop and a push occur in the same cycle on a full FIFO, treat the FIFO as full and drop; on an empty FIFO, the push SHALL appear the next cycle.
REQ-026 SHALL give a request accepted in cycle N with a trigger its first prefetch on pf_valid_o in cycle N+2 when the FIFO is empty.

Reset
REQ-027 SHALL, while rst is high, clear all tracker valid bits, the victim pointer, the FIFO, drop_cnt_o and k, and force the FSM to IDLE.
REQ-028 SHALL drive pf_valid_o = 0, pf_addr_o = 0 and req_ready_o = 0 while rst is high, with req_ready_o = 1 on the first cycle after release.
REQ-029 SHALL abandon any burst in progress when rst asserts mid-burst; no partial burst resumes after release.

Structure
REQ-030 SHALL take addr_t, cla_t, stride_t, the tracker_t struct, LOG2_BLOCK_SIZE = 6 and LOG2_PAGE_SIZE = 12 from shared package ip_stride_pkg.
REQ-031 SHALL instantiate sub-module pf_fifo (parameterised width/depth, registered output, full/empty flags) for the prefetch queue.

Verification
REQ-032 SHALL be covered by this scenario: ip 0x400 with addrs 0x10000, 0x10040, 0x10080, 0x100C0 and THRESH 2, DEGREE 4 -> after the 4th request, prefetches 0x10100, 0x10140, 0x10180, 0x101C0.
REQ-033 SHALL be covered by this scenario: ip 0x500 with addrs 0x20F00, 0x20E00, 0x20D00, 0x20C00 (negative stride -4) -> prefetches 0x20B00, 0x20A00, 0x20900, 0x20800.
REQ-034 SHALL be covered by this scenario: ip 0x600 with stride +0x400 ending at 0x30800 -> only 0x30C00 is issued, then page-cross termination.
REQ-035 SHALL be covered by this scenario: pf_ready_i held 0 with QDEPTH 8 and three triggered DEGREE-4 bursts -> 8 queued, drop_cnt_o = 4, FIFO order preserved.
REQ-036 SHALL be covered by this scenario: TRACKERS 4 with 5 distinct IPs -> the 5th IP evicts tracker 0; re-access to the first IP allocates and produces no prefetch.
REQ-037 SHALL be covered by this scenario: rst asserted on the 2nd ISSUE cycle -> pf_valid_o = 0 and drop_cnt_o = 0 after release, with no further prefetches.
